// File: rtl/freq_counter_pkg.sv
// ----------------------------------------------------------------------------
// freq_counter_pkg
//  Shared definitions for the frequency-counter tile: gate-window FSM state
//  encoding, gate timer / period register width and the period loaded at
//  reset. Used by the gate sequencer, the edge counter and the testbench.
// ----------------------------------------------------------------------------
package freq_counter_pkg;

   // Width of the period register and of the gate timer.
   localparam int PERIOD_W = 12;

   // Window length (clk cycles) in force after reset.
   localparam logic [PERIOD_W-1:0] DEFAULT_PERIOD = 12'd1000;

   // Encoding is visible on dbg_state, so values are fixed explicitly.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_CLEAR = 2'd1,
      ST_COUNT = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

endpackage : freq_counter_pkg

// File: rtl/sync_rise_detect.sv
// ----------------------------------------------------------------------------
// sync_rise_detect
//  Two-flop synchronizer for an asynchronous pin followed by a rising-edge
//  detector. rise_o is high for exactly one clk cycle per low-to-high
//  transition of the synchronized level; a level held high gives one pulse.
//
//  Ports
//   clk      in   system clock
//   rst_n    in   async active-low reset
//   async_i  in   asynchronous input pin
//   rise_o   out  one-cycle pulse on a synchronized rising edge
// ----------------------------------------------------------------------------
module sync_rise_detect (
   input  logic clk,
   input  logic rst_n,
   input  logic async_i,
   output logic rise_o
);

   logic [1:0] sync_q;   // [0] may go metastable, [1] is the clean level
   logic       prev_q;   // synchronized level one cycle earlier

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
         prev_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every flop sample the old value
         // of its predecessor, which is what turns these lines into a shift
         // chain instead of collapsing them into a single wire.
         sync_q <= {sync_q[0], async_i};
         prev_q <= sync_q[1];
      end
   end

   // Pin high at edge k: sync_q[1] rises at edge k+1, so the pulse spans the
   // cycle between edges k+1 and k+2 and is consumed at edge k+2.
   assign rise_o = sync_q[1] & ~prev_q;

endmodule : sync_rise_detect

// File: rtl/freq_gate_sequencer.sv
// ----------------------------------------------------------------------------
// freq_gate_sequencer
//  Gate-window controller for the frequency counter. Holds the measurement
//  period, times each window in clk cycles and issues the clear / enable /
//  latch strobes to the edge counter and the display latch.
//
//  Frame when free running: CLEAR (1) -> COUNT (period) -> LATCH (1) -> ...
//  A reload of the period or a drop of ena aborts the current window without
//  a latch strobe, so the display only ever captures complete windows.
//
//  Ports
//   clk            in   system clock
//   rst_n          in   async active-low reset
//   ena            in   tile enable; low forces IDLE
//   load_period    in   async pin; each rising edge reloads the period
//   period_in      in   new period (quasi-static while load_period toggles)
//   cnt_clr        out  clear edge counter (one-cycle pulse, CLEAR state)
//   cnt_en         out  edge counter gate (high throughout COUNT)
//   latch_stb      out  capture edge count into display (LATCH state)
//   dbg_state      out  current state encoding
//   dbg_clk_count  out  low three bits of the gate timer
// ----------------------------------------------------------------------------
module freq_gate_sequencer
   import freq_counter_pkg::*;
(
   input  logic                clk,
   input  logic                rst_n,
   input  logic                ena,
   input  logic                load_period,
   input  logic [PERIOD_W-1:0] period_in,
   output logic                cnt_clr,
   output logic                cnt_en,
   output logic                latch_stb,
   output logic [1:0]          dbg_state,
   output logic [2:0]          dbg_clk_count
);

   state_t              state_q,    state_d;
   logic [PERIOD_W-1:0] period_q,   period_d;
   logic [PERIOD_W-1:0] gate_cnt_q, gate_cnt_d;
   logic                load_pulse;
   logic                terminal;

   sync_rise_detect u_load_sync (
      .clk     (clk),
      .rst_n   (rst_n),
      .async_i (load_period),
      .rise_o  (load_pulse)
   );

   // Last COUNT cycle. Only evaluated with period_q != 0, so the subtraction
   // never underflows and the timer never needs to pass 2^PERIOD_W-2.
   assign terminal = (gate_cnt_q == period_q - 1'b1);

   // ------------------------------------------------------------------
   // State register, period register and gate timer
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         period_q   <= DEFAULT_PERIOD;
         gate_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         period_q   <= period_d;
         gate_cnt_q <= gate_cnt_d;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic. Priority: !ena > load_pulse > terminal count.
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default before any branch;
      // a path that leaves it unassigned would infer a latch.
      state_d = state_q;
      if (!ena) begin
         state_d = ST_IDLE;
      end else if (load_pulse) begin
         // Abort: skip LATCH so a partial window is never displayed.
         state_d = (period_in == '0) ? ST_IDLE : ST_CLEAR;
      end else begin
         case (state_q)
            ST_IDLE:  if (period_q != '0) state_d = ST_CLEAR;
            ST_CLEAR: state_d = (period_q == '0) ? ST_IDLE : ST_COUNT;
            ST_COUNT: begin
               if (period_q == '0)   state_d = ST_IDLE;
               else if (terminal)    state_d = ST_LATCH;
            end
            ST_LATCH: state_d = (period_q == '0) ? ST_IDLE : ST_CLEAR;
            default:  state_d = ST_IDLE;
         endcase
      end
   end

   // Period reload happens regardless of state so the new value is ready
   // for the COUNT that follows the abort.
   always_comb begin
      period_d = load_pulse ? period_in : period_q;
   end

   // Gate timer: zeroed in CLEAR, counts in COUNT, holds otherwise.
   always_comb begin
      gate_cnt_d = gate_cnt_q;
      case (state_q)
         ST_CLEAR: gate_cnt_d = '0;
         ST_COUNT: gate_cnt_d = gate_cnt_q + 1'b1;
         default:  gate_cnt_d = gate_cnt_q;
      endcase
   end

   // ------------------------------------------------------------------
   // Moore output decode
   // ------------------------------------------------------------------
   always_comb begin
      cnt_clr       = (state_q == ST_CLEAR);
      cnt_en        = (state_q == ST_COUNT);
      latch_stb     = (state_q == ST_LATCH);
      dbg_state     = state_q;
      dbg_clk_count = gate_cnt_q[2:0];
   end

endmodule : freq_gate_sequencer

// File: tb/tb_freq_gate_sequencer.sv
// ----------------------------------------------------------------------------
// tb_freq_gate_sequencer
//  Directed stimulus pushes the expected outcome of every gate window
//  (cnt_en run length and the state that ends it) into a queue; a monitor
//  on the falling clock edge measures each cnt_en run and compares it with
//  the head of the queue. Directed point checks cover reset, state sequence
//  and gate timer values.
// ----------------------------------------------------------------------------
module tb_freq_gate_sequencer;
   import freq_counter_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                ena;
   logic                load_period;
   logic [PERIOD_W-1:0] period_in;
   logic                cnt_clr, cnt_en, latch_stb;
   logic [1:0]          dbg_state;
   logic [2:0]          dbg_clk_count;

   freq_gate_sequencer dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .ena           (ena),
      .load_period   (load_period),
      .period_in     (period_in),
      .cnt_clr       (cnt_clr),
      .cnt_en        (cnt_en),
      .latch_stb     (latch_stb),
      .dbg_state     (dbg_state),
      .dbg_clk_count (dbg_clk_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int     len;
      state_t end_st;
   } win_t;

   win_t exp_q[$];
   int   n_cmp       = 0;
   int   n_fail      = 0;
   int   n_latch_exp = 0;
   int   n_latch_seen = 0;

   // {state, clr, en, stb, count}
   wire [7:0] vec = {dbg_state, cnt_clr, cnt_en, latch_stb, dbg_clk_count};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: actual %0d (0x%0h) required %0d (0x%0h) at %0t",
                  name, act, act, req, req, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input int len, input state_t st);
      win_t w;
      w.len    = len;
      w.end_st = st;
      exp_q.push_back(w);
      if (st == ST_LATCH) n_latch_exp++;
   endtask

   task automatic wait_state(input state_t s, input int budget, input string name);
      int n = 0;
      while (dbg_state != s && n < budget) begin
         step(1);
         n++;
      end
      check(name, dbg_state, s);
   endtask

   // Expected {dbg_state, latch_stb, cnt_clr} in the cycle that ends a window.
   function automatic logic [3:0] end_code(input state_t st);
      case (st)
         ST_LATCH: return 4'b11_1_0;
         ST_CLEAR: return 4'b01_0_1;
         default:  return 4'b00_0_0;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------
   int   run     = 0;
   logic prev_en = 1'b0;

   always @(negedge clk) begin
      if (latch_stb === 1'b1) n_latch_seen++;
      if (cnt_en === 1'b1) begin
         run++;
      end else if (prev_en) begin
         if (exp_q.size() == 0) begin
            check("unexpected_window", run, 0);
         end else begin
            win_t w;
            w = exp_q.pop_front();
            check("win_len", run, w.len);
            check("win_end", {dbg_state, latch_stb, cnt_clr}, end_code(w.end_st));
         end
         run = 0;
      end
      prev_en = (cnt_en === 1'b1);
   end

   // ------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------
   initial begin
      rst_n       = 1'b1;
      ena         = 1'b1;
      load_period = 1'b0;
      period_in   = '0;
      #1 rst_n    = 1'b0;
      #2;
      check("reset_outputs", vec, 8'h00);
      step(2);
      check("reset_held", vec, 8'h00);

      // 1: default period, free running
      push(1000, ST_LATCH);
      rst_n = 1'b1;
      step(1);
      check("t1_clear", dbg_state, ST_CLEAR);
      step(1);
      check("t1_count0", vec, {2'd2, 1'b0, 1'b1, 1'b0, 3'd0});
      wait_state(ST_LATCH, 1100, "t1_latch");
      step(1);
      check("t1_clear_after_latch", dbg_state, ST_CLEAR);
      step(1);
      check("t1_count_again", vec, {2'd2, 1'b0, 1'b1, 1'b0, 3'd0});

      // 2: reload period 5 three cycles into a window
      push(3, ST_CLEAR);
      push(5, ST_LATCH);
      load_period = 1'b1;
      period_in   = 12'd5;
      step(3);
      load_period = 1'b0;
      check("t2_abort_clear", dbg_state, ST_CLEAR);
      for (int i = 0; i < 5; i++) begin
         step(1);
         check("t2_count", vec, {2'd2, 1'b0, 1'b1, 1'b0, 3'(i)});
      end
      step(1);
      check("t2_latch", vec[7:3], {2'd3, 1'b0, 1'b0, 1'b1});
      step(1);
      check("t2_clear", vec[7:3], {2'd1, 1'b1, 1'b0, 1'b0});

      // 3: period 0 parks the FSM in IDLE
      push(2, ST_IDLE);
      load_period = 1'b1;
      period_in   = 12'd0;
      step(3);
      load_period = 1'b0;
      check("t3_idle", dbg_state, ST_IDLE);
      for (int i = 0; i < 50; i++) begin
         step(1);
         check("t3_quiet", vec[7:3], 5'd0);
      end

      // 4: period 20, reload 8 at COUNT cycle 10
      load_period = 1'b1;
      period_in   = 12'd20;
      step(3);
      load_period = 1'b0;
      check("t4_start", dbg_state, ST_CLEAR);
      step(1);
      check("t4_count0", vec, {2'd2, 1'b0, 1'b1, 1'b0, 3'd0});
      step(10);
      check("t4_count10", vec, {2'd2, 1'b0, 1'b1, 1'b0, 3'd2});
      push(13, ST_CLEAR);
      push(8, ST_LATCH);
      load_period = 1'b1;
      period_in   = 12'd8;
      step(3);
      check("t4_abort_clr", cnt_clr, 1'b1);
      load_period = 1'b0;
      step(1);
      check("t4_new_count0", vec, {2'd2, 1'b0, 1'b1, 1'b0, 3'd0});
      step(8);
      check("t4_latch", dbg_state, ST_LATCH);

      // 5: drop ena at COUNT cycle 3, then resume
      step(2);
      step(3);
      check("t5_count3", vec, {2'd2, 1'b0, 1'b1, 1'b0, 3'd3});
      push(4, ST_IDLE);
      ena = 1'b0;
      step(1);
      check("t5_idle", vec[7:3], 5'd0);
      step(3);
      check("t5_idle_held", vec[7:3], 5'd0);
      push(8, ST_LATCH);
      ena = 1'b1;
      step(1);
      check("t5_resume_clear", dbg_state, ST_CLEAR);
      wait_state(ST_LATCH, 20, "t5_full_latch");

      // 6: long load level reloads once; async reset mid-COUNT
      step(2);
      check("t6_count0", vec, {2'd2, 1'b0, 1'b1, 1'b0, 3'd0});
      step(2);
      push(5, ST_CLEAR);
      push(9, ST_LATCH);
      push(9, ST_LATCH);
      push(9, ST_LATCH);
      load_period = 1'b1;
      period_in   = 12'd9;
      step(30);
      load_period = 1'b0;
      wait_state(ST_LATCH, 20, "t6_latch3");
      step(4);
      check("t6_pre_reset", vec, {2'd2, 1'b0, 1'b1, 1'b0, 3'd2});
      push(2, ST_IDLE);
      rst_n = 1'b0;
      #1;
      check("t6_reset_immediate", vec, 8'h00);
      step(3);
      push(1000, ST_LATCH);
      rst_n = 1'b1;
      step(1);
      check("t6_release_clear", dbg_state, ST_CLEAR);
      wait_state(ST_LATCH, 1100, "t6_default_period");

      ena = 1'b0;
      step(5);
      check("queue_drained", exp_q.size(), 0);
      check("latch_strobes", n_latch_seen, n_latch_exp);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_freq_gate_sequencer
